// File: rtl/rf_synth_prog.sv
// rf_synth_prog: hop channel -> RF synth frequency word, 3-wire serializer, settle timer.
// Define SYNTH_LOCKDET_EN to replace the fixed settle timer with lock-detect wait.
module rf_synth_prog #(
  parameter int         CLKDIV      = 3,
  parameter logic [3:0] SYN_ADDR    = 4'h5,
  parameter int         RX_IF_MHZ   = 2,
  parameter int         SETTLE_CYC  = 900,
  parameter int         LOCK_TO_CYC = 1200
) (
  input  logic        clk_6M,
  input  logic        rstz,
  input  logic        fk_chg_p,
  input  logic [6:0]  fk,
  input  logic        txmode,
  input  logic        lock_det,
  output logic        spi_clk,
  output logic        spi_data,
  output logic        spi_le,
  output logic        busy,
  output logic        synth_ready,
  output logic        synth_ready_p,
  output logic        fk_err_p,
`ifdef SYNTH_LOCKDET_EN
  output logic        lock_err,
`endif
  output logic [11:0] cur_freq
);

  typedef enum logic [2:0] {
    IDLE, LOAD, SHIFT, LATCH, SETTLE
  } state_e;

  localparam int MAXC = (SETTLE_CYC > LOCK_TO_CYC)
                      ? SETTLE_CYC : LOCK_TO_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [15:0]   sh_q, sh_d;
  logic          pend_q, pend_d;
  logic [6:0]    pfk_q, pfk_d;
  logic          ptx_q, ptx_d;
  logic          rdy_q, rdy_d;
  logic          err_q, err_d;
  logic [11:0]   freq_q, freq_d;

  logic          acc;
  logic          rej;
  logic          done;
  logic [11:0]   freq_w;

  assign acc = fk_chg_p && (fk <= 7'd78);
  assign rej = fk_chg_p && !acc;

  assign freq_w = 12'd2402 + {5'd0, pfk_q}
                - (ptx_q ? 12'd0 : 12'(RX_IF_MHZ));

`ifdef SYNTH_LOCKDET_EN
  logic ls1_q, ls2_q;
  logic lerr_q, lerr_d;
  logic locked;
  logic tmo;

  // Lock only counts once the minimum dwell has elapsed
  assign locked = ls2_q && (cnt_q >= CW'(15));
  assign tmo    = cnt_q == CW'(LOCK_TO_CYC - 1);
  assign done   = locked || tmo;

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      ls1_q  <= 1'b0;
      ls2_q  <= 1'b0;
      lerr_q <= 1'b0;
    end else begin
      ls1_q  <= lock_det;
      ls2_q  <= ls1_q;
      lerr_q <= lerr_d;
    end
  end

  always_comb begin
    lerr_d = lerr_q;
    if (state_q == LOAD)
      lerr_d = 1'b0;
    else if (state_q == SETTLE && tmo && !locked)
      lerr_d = 1'b1;
  end

  assign lock_err = lerr_q;
`else
  logic unused_lock_det;
  assign unused_lock_det = lock_det;
  assign done = cnt_q == CW'(SETTLE_CYC - 1);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    pend_d  = pend_q;
    pfk_d   = pfk_q;
    ptx_d   = ptx_q;
    rdy_d   = rdy_q;
    freq_d  = freq_q;
    err_d   = rej;
    if (acc) begin
      pfk_d = fk;
      ptx_d = txmode;
    end
    unique case (state_q)
      IDLE: begin
        if (acc) state_d = LOAD;
      end
      LOAD: begin
        sh_d    = {SYN_ADDR, freq_w};
        freq_d  = freq_w;
        rdy_d   = 1'b0;
        pend_d  = acc;
        cnt_d   = '0;
        bit_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (acc) pend_d = 1'b1;
        if (cnt_q == CW'(2 * CLKDIV - 1)) begin
          cnt_d = '0;
          sh_d  = {sh_q[14:0], 1'b0};
          bit_d = bit_q + 4'd1;
          if (bit_q == 4'd15) state_d = LATCH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LATCH: begin
        if (acc) pend_d = 1'b1;
        if (cnt_q == CW'(CLKDIV - 1)) begin
          cnt_d   = '0;
          state_d = (pend_q || acc) ? LOAD : SETTLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + 1'b1;
        // A new request on terminal count keeps ready low afterwards
        if (done) begin
          rdy_d   = !acc;
          state_d = acc ? LOAD : IDLE;
        end else if (acc) begin
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      pend_q  <= 1'b0;
      pfk_q   <= '0;
      ptx_q   <= 1'b0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      freq_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      pend_q  <= pend_d;
      pfk_q   <= pfk_d;
      ptx_q   <= ptx_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      freq_q  <= freq_d;
    end
  end

  assign busy          = state_q != IDLE;
  assign spi_data      = (state_q == SHIFT) && sh_q[15];
  assign spi_clk       = (state_q == SHIFT) && (cnt_q >= CW'(CLKDIV));
  assign spi_le        = state_q == LATCH;
  assign synth_ready_p = (state_q == SETTLE) && done;
  assign synth_ready   = rdy_q || synth_ready_p;
  assign fk_err_p      = err_q;
  assign cur_freq      = freq_q;

endmodule

// File: tb/tb_rf_synth_prog.sv
// tb_rf_synth_prog: scoreboard bench for rf_synth_prog.
// A timeline reference model predicts frames, ready pulses and rejects.
module tb_rf_synth_prog;

  logic        clk_6M = 1'b0;
  logic        rstz;
  logic        fk_chg_p;
  logic [6:0]  fk;
  logic        txmode;
  logic        lock_det;
  logic        spi_clk;
  logic        spi_data;
  logic        spi_le;
  logic        busy;
  logic        synth_ready;
  logic        synth_ready_p;
  logic        fk_err_p;
  logic [11:0] cur_freq;
`ifdef SYNTH_LOCKDET_EN
  logic        lock_err;
`endif

  rf_synth_prog dut (
    .clk_6M        (clk_6M),
    .rstz          (rstz),
    .fk_chg_p      (fk_chg_p),
    .fk            (fk),
    .txmode        (txmode),
    .lock_det      (lock_det),
    .spi_clk       (spi_clk),
    .spi_data      (spi_data),
    .spi_le        (spi_le),
    .busy          (busy),
    .synth_ready   (synth_ready),
    .synth_ready_p (synth_ready_p),
    .fk_err_p      (fk_err_p),
`ifdef SYNTH_LOCKDET_EN
    .lock_err      (lock_err),
`endif
    .cur_freq      (cur_freq)
  );

  always #5 clk_6M = ~clk_6M;

  int cyc = 0;
  always @(posedge clk_6M) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_frame[$];
  int          exp_rdy[$];
  int          exp_err[$];

  // Reference model: s = cycle of the strobe that launched the frame in flight
  int         s;
  bit         active;
  bit         pend;
  logic [6:0] pfk;
  bit         ptx;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at cyc %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic miss(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got event want none at cyc %0d", nm, cyc);
  endtask

  function automatic logic [15:0] frame_of(input int f, input bit tx);
    int fr;
    fr = 2402 + f - (tx ? 0 : 2);
    return {4'h5, fr[11:0]};
  endfunction

  task automatic launch(input int now, input logic [6:0] f, input bit tx);
    s      = now;
    active = 1'b1;
    exp_frame.push_back(frame_of(int'(f), tx));
  endtask

  task automatic model_step(input int now, input bit stb,
                            input logic [6:0] f, input bit tx);
    if (stb) begin
      if (f > 7'd78) begin
        exp_err.push_back(now + 1);
      end else if (active && now >= s + 1 && now <= s + 100) begin
        pend = 1'b1;
        pfk  = f;
        ptx  = tx;
      end else begin
        launch(now, f, tx);
      end
    end
    if (active && pend && now == s + 100) begin
      pend = 1'b0;
      launch(now, pfk, ptx);
    end
    if (active && !pend && now == s + 999) exp_rdy.push_back(now + 1);
    if (active && now >= s + 1000) active = 1'b0;
  endtask

  task automatic tick(input bit stb, input logic [6:0] f, input bit tx);
    @(negedge clk_6M);
    fk_chg_p = stb;
    fk       = f;
    txmode   = tx;
    model_step(cyc, stb, f, tx);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 7'd0, 1'b0);
  endtask

  task automatic strobe_after(input int gap, input logic [6:0] f,
                              input bit tx);
    idle(gap - 1);
    tick(1'b1, f, tx);
  endtask

  // Monitor: rebuilds frames from the pins and pops the scoreboard
  logic [15:0] cap;
  int          ncap;
  int          hi_len;
  int          le_len;
  bit          prev_clk;
  bit          prev_le;

  initial begin
    logic [15:0] e;
    ncap = 0; hi_len = 0; le_len = 0; prev_clk = 0; prev_le = 0;
    cap = '0;
    forever begin
      @(negedge clk_6M);
      if (!rstz) begin
        ncap = 0; hi_len = 0; le_len = 0; prev_clk = 0; prev_le = 0;
      end else begin
        if (spi_clk && !prev_clk) begin
          cap = {cap[14:0], spi_data};
          ncap++;
        end
        if (spi_clk) hi_len++;
        else if (prev_clk) begin
          chk("sclk_high", hi_len, 3);
          hi_len = 0;
        end
        if (spi_le) begin
          if (!prev_le) begin
            if (exp_frame.size() == 0) miss("frame_unexpected");
            else begin
              e = exp_frame.pop_front();
              chk("frame", cap, e);
              chk("nbits", ncap, 16);
              chk("cur_freq", cur_freq, e[11:0]);
            end
            ncap = 0;
          end
          le_len++;
        end else if (prev_le) begin
          chk("le_len", le_len, 3);
          le_len = 0;
        end
        if (synth_ready_p) begin
          if (exp_rdy.size() == 0) miss("ready_unexpected");
          else chk("ready_cyc", cyc, exp_rdy.pop_front());
          chk("ready_level", synth_ready, 1);
        end
        if (fk_err_p) begin
          if (exp_err.size() == 0) miss("err_unexpected");
          else chk("err_cyc", cyc, exp_err.pop_front());
        end
        prev_clk = spi_clk;
        prev_le  = spi_le;
      end
    end
  end

  initial begin
    rstz = 1'b0; fk_chg_p = 1'b0; fk = '0; txmode = 1'b0; lock_det = 1'b0;
    active = 1'b0; pend = 1'b0; s = 0; pfk = '0; ptx = 1'b0;
    repeat (3) @(negedge clk_6M);
    chk("rst_clk", spi_clk, 0);
    chk("rst_data", spi_data, 0);
    chk("rst_le", spi_le, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", synth_ready, 0);
    chk("rst_freq", cur_freq, 0);
    chk("rst_err", fk_err_p, 0);
    rstz = 1'b1;

    tick(1'b1, 7'd0, 1'b1);
    idle(1100);
    tick(1'b1, 7'd78, 1'b0);
    idle(1100);

    tick(1'b1, 7'd79, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 7'd0, 1'b0);
      chk("busy_rej", busy, 0);
    end
    idle(20);

    tick(1'b1, 7'd10, 1'b1);
    strobe_after(40, 7'd20, 1'b1);
    strobe_after(20, 7'd30, 1'b1);
    idle(1200);

    tick(1'b1, 7'd5, 1'b1);
    strobe_after(600, 7'd6, 1'b1);
    idle(1100);

    tick(1'b1, 7'd3, 1'b1);
    strobe_after(1000, 7'd4, 1'b0);
    tick(1'b0, 7'd0, 1'b0);
    chk("ready_one_cyc", synth_ready, 0);
    idle(1100);

    tick(1'b1, 7'd7, 1'b1);
    strobe_after(100, 7'd8, 1'b0);
    idle(1200);

    tick(1'b1, 7'd40, 1'b1);
    idle(30);
    @(negedge clk_6M);
    fk_chg_p = 1'b0;
    rstz = 1'b0;
    #1;
    chk("rstmid_clk", spi_clk, 0);
    chk("rstmid_data", spi_data, 0);
    chk("rstmid_le", spi_le, 0);
    chk("rstmid_busy", busy, 0);
    exp_frame.delete();
    exp_rdy.delete();
    active = 1'b0;
    pend   = 1'b0;
    repeat (3) @(negedge clk_6M);
    chk("rstmid_freq", cur_freq, 0);
    rstz = 1'b1;
    idle(5);
    tick(1'b1, 7'd50, 1'b0);
    idle(1100);

    for (int n = 0; n < 40; n++) begin
      int gap;
      gap = ($urandom % 2 == 0) ? int'($urandom_range(1, 150))
                                : int'($urandom_range(800, 1100));
      strobe_after(gap, 7'($urandom_range(0, 85)), 1'($urandom % 2));
    end
    idle(1200);
    chk("left_frames", exp_frame.size(), 0);
    chk("left_ready", exp_rdy.size(), 0);
    chk("left_err", exp_err.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_synth_prog.md
Name: rf_synth_prog

Overview:
- Consumer end of the hop-selection channel interface: takes the channel index fk and its change strobe, and converts fk into an RF synthesizer frequency word.
- Serializes that word to the external radio over a 3-wire interface (SCLK/SDATA/LE), then times PLL settling before declaring the synthesizer ready.
- Sits between the hop-selection logic and the RF front-end pins.

Parameters:
- CLKDIV, 3: clk_6M cycles per SCLK half-period (default gives 1 MHz SCLK).
- SYN_ADDR, 4'h5: 4-bit synthesizer register address prefixed to every frame.
- RX_IF_MHZ, 2: IF offset in MHz subtracted from the frequency in receive mode.
- SETTLE_CYC, 900: PLL settle time in clk_6M cycles (150 us).
- LOCK_TO_CYC, 1200: lock-detect timeout in cycles (used only with the optional feature).

Ports:
- clk_6M  input  1  system clock, 6 MHz.
- rstz  input  1  asynchronous active-low reset.
- fk_chg_p  input  1  one-cycle strobe: a new fk is valid this cycle.
- fk  input  7  channel index; legal range 0..78.
- txmode  input  1  sampled together with fk; 1 = transmit, 0 = receive.
- lock_det  input  1  synthesizer lock indicator (used only with SYNTH_LOCKDET_EN).
- spi_clk  output  1  serial clock to the radio.
- spi_data  output  1  serial data, MSB first.
- spi_le  output  1  latch-enable pulse after the last bit.
- busy  output  1  high in every state except IDLE.
- synth_ready  output  1  level: the programmed channel is settled.
- synth_ready_p  output  1  one-cycle pulse when synth_ready rises.
- fk_err_p  output  1  one-cycle pulse: an fk > 78 was rejected.
- cur_freq  output  12  frequency in MHz of the last accepted channel.

Behaviour:
- Reset: all outputs 0, cur_freq = 0, state IDLE, pending flag cleared.
- Reset mid-frame aborts immediately: spi_clk, spi_data and spi_le all return to 0 with no partial LE.
- Acceptance: on fk_chg_p with fk <= 78, capture fk and txmode.
  - freq = 2402 + fk - (txmode ? 0 : RX_IF_MHZ), computed at 12-bit width.
  - Frame = {SYN_ADDR, freq}, 16 bits.
- Rejection: fk_chg_p with fk > 78 produces fk_err_p on the next cycle. The event is otherwise ignored: state, cur_freq and pending are unchanged.
- IDLE -> LOAD on an accepted fk_chg_p.
- LOAD, 1 cycle:
  - Load the shift register and update cur_freq.
  - Drop synth_ready.
  - Clear pending.
  - Go to SHIFT.
- SHIFT, 16 bits, each held 2*CLKDIV cycles:
  - spi_data changes at the start of a bit.
  - spi_clk is low for the first CLKDIV cycles of the bit and high for the second, so the radio samples on the rising edge.
  - After bit 0 completes, spi_data = 0 and the block goes to LATCH.
- LATCH: spi_le high for CLKDIV cycles, spi_clk low throughout.
  - At exit, if pending is set, go to LOAD.
  - Otherwise go to SETTLE.
- SETTLE:
  - Counter runs 0..SETTLE_CYC-1.
  - On terminal count: synth_ready goes to 1, synth_ready_p pulses in the same cycle, then the block returns to IDLE.
- fk_chg_p during SHIFT or LATCH:
  - The new values go into pending registers and the pending flag is set; the current frame completes unmodified.
  - Latest request wins when several arrive.
- fk_chg_p during SETTLE: abort settling and go to LOAD next cycle. No synth_ready_p is generated for the aborted channel.
- fk_chg_p on the final LATCH cycle: treated as pending, so the next state is LOAD.
- fk_chg_p in the same cycle as the settle terminal count:
  - synth_ready_p still fires.
  - The next state is LOAD, so synth_ready is high for one cycle only.
- Total latency from accepted fk_chg_p to synth_ready_p at defaults: 1 (LOAD) + 96 (SHIFT) + 3 (LATCH) + 900 (SETTLE) = 1000 cycles.

Optional Feature:
- Macro: SYNTH_LOCKDET_EN.
- Defined: SETTLE is replaced by LOCKWAIT.
  - lock_det is double-flop synchronized.
  - synth_ready rises on the first cycle the synchronized lock_det is 1, after a minimum of 16 cycles in LOCKWAIT.
  - If the counter reaches LOCK_TO_CYC without lock, synth_ready_p still fires, and a sticky lock_err output (1 bit, cleared on next LOAD) is set.
  - Abort/pending rules are identical to SETTLE.
- Undefined: fixed SETTLE_CYC timer; the lock_det port exists but is ignored; lock_err is absent.

Test Plan:
- Reset, then fk_chg_p with fk=0, txmode=1 -> frame 0x5962 shifted MSB first, 16 rising spi_clk edges, spi_le high 3 cycles, synth_ready_p exactly 1000 cycles after the strobe, cur_freq=2402.
- fk=78, txmode=0 -> freq 2478, frame 0x59AE, cur_freq=2478.
- fk=79 strobe in IDLE -> fk_err_p one cycle later, busy stays 0, no spi_clk edges.
- fk=10 strobe, then fk=20 at cycle 40 and fk=30 at cycle 60 -> first frame 0x596C completes, then exactly one further frame 0x5980 (fk=30), with a single synth_ready_p at the end.
- fk=5 strobe, then fk=6 strobe 500 cycles into SETTLE -> no synth_ready_p for fk=5; a new frame 0x5968 follows, and synth_ready_p fires 1000 cycles after the second strobe.
- Assert rstz low in the middle of SHIFT -> all serial outputs 0 immediately, busy=0, spi_le never pulses.
